slc3_mem_responder: RTL

Wait-state memory responder for the SLC-3 CPU bus. It answers the CPU's read/write requests (`ADDR`, `Data_to_SRAM`, `OE`, `WE`) from an internal word array, or from a memory-mapped I/O register at one reserved address, after a programmable number of wait states. It returns read data on `Data_from_SRAM` and signals completion with a one-cycle ready pulse `R`. It sits between `slc3` and the board I/O and replaces the zero-latency test memory when the CPU's ready handshake is exercised.

---
 rtl/slc3_mem_responder.sv | 109 ++++++++++
 1 files changed

// File: rtl/slc3_mem_responder.sv
// Wait-state memory responder for the SLC-3 bus: word array plus one MMIO
// register (switches in, hex display out), completion signalled by a one-cycle R.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for OE/WE; latches address, data and operation type
// S_WAIT    | counting wait states down; access performed when count hits 0
// S_DONE    | R high for this single cycle
// S_RELEASE | request still held after DONE; wait for OE=WE=0
module slc3_mem_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] MMIO_ADDR   = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_to_SRAM,
  input  logic        OE,
  input  logic        WE,
  input  logic [9:0]  SW,
  output logic [15:0] Data_from_SRAM,
  output logic        R,
  output logic [15:0] HEX_REG
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
  localparam int         DEPTH   = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DONE    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [15:0]        addr_q;
  logic [15:0]        data_q;
  logic               wr_q;
  logic [15:0]        mem [0:DEPTH-1];

  logic               access;
  logic               is_mmio;
  logic [ADDR_W-1:0]  idx;
  logic               mem_we;

  assign access  = (state == S_WAIT) && (cnt == 4'd0);
  assign is_mmio = (addr_q == MMIO_ADDR);
  assign idx     = addr_q[ADDR_W-1:0];
  assign mem_we  = access && wr_q && !is_mmio;

  // Array is deliberately not reset so its contents survive Reset. An aborted
  // access never commits because Reset forces state away from S_WAIT.
  always_ff @(posedge Clk) begin
    if (mem_we)
      mem[idx] <= data_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state          <= S_IDLE;
      cnt            <= 4'd0;
      addr_q         <= 16'h0000;
      data_q         <= 16'h0000;
      wr_q           <= 1'b0;
      R              <= 1'b0;
      Data_from_SRAM <= 16'h0000;
      HEX_REG        <= 16'h0000;
    end else begin
      R <= 1'b0;
      case (state)
        S_IDLE: begin
          if (WE || OE) begin
            addr_q <= ADDR;
            data_q <= Data_to_SRAM;
            wr_q   <= WE;
            cnt    <= WAIT_LD;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            R     <= 1'b1;
            state <= S_DONE;
            if (is_mmio) begin
              if (wr_q) HEX_REG        <= data_q;
              else      Data_from_SRAM <= {6'b0, SW};
            end else if (!wr_q) begin
              Data_from_SRAM <= mem[idx];
            end
          end
        end
        S_DONE: begin
          state <= (OE || WE) ? S_RELEASE : S_IDLE;
        end
        S_RELEASE: begin
          if (!OE && !WE)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
